modport_router: RTL and testbench
=================================

Name: modport_router

Overview:
- Single-output slice of the 1x3 packet router.
- Accepts byte-serial packets on data_in/pkt_valid and checks the trailing parity byte.
- Packets addressed to this slice are buffered in a byte FIFO; packets for any other port are discarded.
- The read side drains the FIFO through a valid_out/read_enb handshake.

Parameters:
- PORT_ADDR, 0, 2-bit destination address served by this slice (legal values 0..2).
- FIFO_DEPTH, 16, number of byte entries in the output FIFO (power of two).
- TIMEOUT, 30, number of idle-read cycles after which unread FIFO contents are flushed.

Ports:
- clock  in  1  rising-edge clock for all logic.
- resetn  in  1  synchronous reset, active-high; the port keeps the codebase name.
- data_in  in  8  packet byte from the sender.
- pkt_valid  in  1  high during header and payload bytes; low when the parity byte is presented.
- read_enb  in  1  read request from the consumer.
- busy  out  1  slice cannot accept a byte this cycle; the sender holds data_in and pkt_valid.
- error  out  1  parity mismatch on the last accepted packet.
- valid_out  out  1  FIFO holds at least one byte.
- data_out  out  8  byte read from the FIFO.

Behaviour:
- Reset:
  - Sampled at a clock edge while resetn = 1.
  - Clears FIFO pointers, count, timeout counter and parity accumulator.
  - FSM -> IDLE; busy = 0, error = 0, valid_out = 0, data_out = 8'h00.
  - Overrides a packet in progress; that packet is lost.
- Packet format:
  - Header byte: bits[7:2] = payload length (informational), bits[1:0] = destination address.
  - Then the payload bytes, then one parity byte.
  - Required parity = XOR of the header and all payload bytes.
- Byte acceptance: a byte is accepted at a rising edge only when busy = 0.
- busy = fifo_full or FSM in CHECK (combinational).
- FSM states:
  - IDLE:
    - pkt_valid = 1 and data_in[1:0] == PORT_ADDR -> store header in FIFO, parity_acc <= header, go to LOAD.
    - Any other address with pkt_valid = 1 -> go to DROP; nothing stored.
  - LOAD:
    - pkt_valid = 1 -> store byte, parity_acc ^= byte.
    - pkt_valid = 0 -> byte is the parity; latch it, go to CHECK. Parity is not stored.
  - CHECK (1 cycle):
    - error <= (parity_acc != latched parity); go to IDLE. busy = 1 in this state.
  - DROP:
    - Bytes are consumed (busy = 0), never stored.
    - The first byte with pkt_valid = 0 ends the packet -> IDLE.
    - error is unchanged.
- error is held until the next CHECK updates it.
- FIFO full during LOAD: busy = 1 and the byte is not taken. The sender holds it; acceptance resumes on the edge after space frees.
- Read side:
  - valid_out = (count != 0).
  - On a rising edge with read_enb = 1 and valid_out = 1: data_out <= head byte, read pointer +1, count -1.
  - Otherwise data_out holds its value.
  - Reading from an empty FIFO does nothing.
- Simultaneous read and write in one cycle: both happen and count is unchanged. A full FIFO with a simultaneous read still reports busy = 1 that cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Timeout flush:
  - The counter increments each cycle with valid_out = 1 and read_enb = 0.
  - It clears on any read or when the FIFO is empty.
  - Reaching TIMEOUT empties the FIFO (count = 0, pointers equal) at that edge; FSM and error are unaffected.

Test Plan:
- Reset: resetn = 1 for 2 cycles with random inputs -> busy = 0, error = 0, valid_out = 0, data_out = 8'h00.
- Good packet (PORT_ADDR = 0):
  - Stimulus: header 8'h0C, payload 8'h11, 8'h22, 8'h33, parity 8'h0C^8'h11^8'h22^8'h33 = 8'h0C.
  - Response: error = 0 after CHECK, valid_out = 1.
  - Then read_enb = 1 for 4 cycles -> data_out = 0C, 11, 22, 33, then valid_out = 0.
- Bad parity: same packet with parity 8'hFF -> error = 1 the cycle after CHECK, held until the next packet's CHECK.
- Drop: header 8'h05 (address 1) with 1 payload byte and parity -> valid_out stays 0, error unchanged, busy stays 0.
- Full FIFO: 16-byte packet, no reads -> busy = 1 on the 17th byte. One read -> that byte is accepted next edge; the final stream order is preserved.
- Timeout: store a 3-byte packet and keep read_enb = 0 for 30 cycles -> valid_out = 0 after the 30th cycle; a subsequent packet is stored normally.

Source files
------------

// File: rtl/modport_router.sv
// modport_router: one output slice of the 1x3 packet router; parity-checks packets,
// buffers those addressed to PORT_ADDR in a byte FIFO and flushes unread data on timeout.
module modport_router #(
   parameter logic [1:0] PORT_ADDR  = 2'd0,
   parameter int         FIFO_DEPTH = 16,
   parameter int         TIMEOUT    = 30
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] data_in,
   input  logic       pkt_valid,
   input  logic       read_enb,
   output logic       busy,
   output logic       error,
   output logic       valid_out,
   output logic [7:0] data_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;
   state_t state;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic [TW-1:0] tcnt;
   logic [7:0] parity_acc, parity;
   logic full, wr, rd, flush;
   assign full      = count == (AW+1)'(FIFO_DEPTH);
   assign busy      = full || state == CHECK;
   assign valid_out = count != 0;
   assign wr        = !busy && pkt_valid && ((state == IDLE && data_in[1:0] == PORT_ADDR) || state == LOAD);
   assign rd        = read_enb && valid_out;
   assign flush     = valid_out && !read_enb && tcnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clock)
      if (wr) mem[wptr] <= data_in;
   always_ff @(posedge clock) begin
      if (resetn) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         tcnt       <= '0;
         parity_acc <= '0;
         parity     <= '0;
         error      <= 1'b0;
         data_out   <= '0;
         state      <= IDLE;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (rd) data_out <= mem[rptr];
         // a flush drops everything, including a byte written on the same edge
         rptr  <= flush ? wptr + AW'(wr) : rptr + AW'(rd);
         count <= flush ? '0 : count + (AW+1)'(wr) - (AW+1)'(rd);
         tcnt  <= (rd || !valid_out || flush) ? '0 : tcnt + TW'(1);
         unique case (state)
            IDLE:
               if (!busy && pkt_valid) begin
                  parity_acc <= data_in;
                  state      <= data_in[1:0] == PORT_ADDR ? LOAD : DROP;
               end
            LOAD:
               if (!busy) begin
                  if (pkt_valid) parity_acc <= parity_acc ^ data_in;
                  else begin
                     parity <= data_in;
                     state  <= CHECK;
                  end
               end
            CHECK: begin
               error <= parity_acc != parity;
               state <= IDLE;
            end
            DROP:
               if (!busy && !pkt_valid) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_modport_router.sv
// tb_modport_router: directed packets; stored bytes go to a scoreboard queue that a
// read monitor pops and compares, flag checks are made inline by the stimulus.
module tb_modport_router;
   logic clock = 1'b0;
   logic resetn, pkt_valid, read_enb, busy, error, valid_out;
   logic [7:0] data_in, data_out, par;
   logic [7:0] sb [$];
   int passed = 0, total = 0, vcycles = 0;

   modport_router #(.PORT_ADDR(2'd0), .FIFO_DEPTH(16), .TIMEOUT(30)) dut (
      .clock(clock), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid),
      .read_enb(read_enb), .busy(busy), .error(error), .valid_out(valid_out),
      .data_out(data_out));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(posedge clock)
      if (!resetn && read_enb && valid_out) begin
         #1;
         if (sb.size() == 0) check("read_unexpected", 32'(data_out), 32'hFFFF_FFFF);
         else check("data_out", 32'(data_out), 32'(sb.pop_front()));
      end

   always @(negedge clock) if (valid_out === 1'b1) vcycles++;

   task automatic send_byte(input logic [7:0] d, input logic v, input logic store);
      int guard = 0;
      @(negedge clock);
      data_in = d;
      pkt_valid = v;
      while (busy && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 100) check("busy_timeout", 32'(guard), 32'd0);
      @(posedge clock);
      if (store) sb.push_back(d);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         read_enb = 1'b1;
      end
      @(negedge clock);
      read_enb = 1'b0;
   endtask

   initial begin
      resetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         data_in = 8'($urandom);
         pkt_valid = 1'($urandom);
         read_enb = 1'($urandom);
         @(negedge clock);
      end
      check("rst_busy", 32'(busy), 0);
      check("rst_error", 32'(error), 0);
      check("rst_valid", 32'(valid_out), 0);
      check("rst_data", 32'(data_out), 0);
      resetn = 1'b0;
      data_in = 8'h00;
      pkt_valid = 1'b0;
      read_enb = 1'b0;

      // good packet
      send_byte(8'h0C, 1, 1);
      send_byte(8'h11, 1, 1);
      send_byte(8'h22, 1, 1);
      send_byte(8'h33, 1, 1);
      send_byte(8'h0C, 0, 0);
      @(negedge clock);
      check("check_busy", 32'(busy), 1);
      @(negedge clock);
      check("good_error", 32'(error), 0);
      check("good_valid", 32'(valid_out), 1);
      drain(4);
      check("good_empty", 32'(valid_out), 0);

      // bad parity
      send_byte(8'h0C, 1, 1);
      send_byte(8'h11, 1, 1);
      send_byte(8'h22, 1, 1);
      send_byte(8'h33, 1, 1);
      send_byte(8'hFF, 0, 0);
      @(negedge clock);
      check("bad_error_in_check", 32'(error), 0);
      @(negedge clock);
      check("bad_error", 32'(error), 1);
      drain(4);
      check("bad_error_held", 32'(error), 1);

      // packet for another port is dropped
      send_byte(8'h05, 1, 0);
      check("drop_busy", 32'(busy), 0);
      send_byte(8'hAA, 1, 0);
      send_byte(8'hAF, 0, 0);
      @(negedge clock);
      check("drop_valid", 32'(valid_out), 0);
      check("drop_busy_end", 32'(busy), 0);
      check("drop_error", 32'(error), 1);

      // full FIFO back-pressure
      par = 8'h40;
      send_byte(8'h40, 1, 1);
      for (int i = 1; i < 16; i++) begin
         send_byte(8'(i), 1, 1);
         par ^= 8'(i);
      end
      @(negedge clock);
      data_in = 8'd16;
      check("full_busy", 32'(busy), 1);
      read_enb = 1'b1;
      @(negedge clock);
      read_enb = 1'b0;
      check("full_freed", 32'(busy), 0);
      @(posedge clock);
      sb.push_back(8'd16);
      par ^= 8'd16;
      send_byte(par, 0, 0);
      @(negedge clock);
      @(negedge clock);
      check("full_error", 32'(error), 0);
      drain(16);
      check("full_empty", 32'(valid_out), 0);

      // timeout flush
      send_byte(8'h08, 1, 1);
      vcycles = 0;
      send_byte(8'hA1, 1, 1);
      send_byte(8'hB2, 1, 1);
      send_byte(8'h08 ^ 8'hA1 ^ 8'hB2, 0, 0);
      for (int i = 0; i < 60 && valid_out; i++) @(negedge clock);
      check("flush_valid", 32'(valid_out), 0);
      check("flush_cycles", 32'(vcycles), 30);
      sb.delete();
      send_byte(8'h04, 1, 1);
      send_byte(8'h5A, 1, 1);
      send_byte(8'h5E, 0, 0);
      @(negedge clock);
      @(negedge clock);
      check("post_flush_valid", 32'(valid_out), 1);
      check("post_flush_error", 32'(error), 0);
      drain(2);
      check("end_empty", 32'(valid_out), 0);
      check("sb_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
